// File: rtl/c3lib_scan_unload_pkg.sv
// Shared types and sizing helpers for the scan-chain unload collector.
// Imported by the deserializer and the top-level unload controller.
package c3lib_scan_unload_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } unload_state_e;

  // Number of output words needed to carry the whole chain.
  function automatic int calc_nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Valid bit count in the final word (a full word when the chain divides evenly).
  function automatic int calc_last_bits(input int chain_len, input int word_w);
    int rem_bits;
    rem_bits = chain_len % word_w;
    return (rem_bits == 0) ? word_w : rem_bits;
  endfunction

endpackage

// File: rtl/c3lib_scan_deser.sv
// Serial-to-parallel assembly register for the unload path.
// A completed word is offered combinationally on word_out and parks here until taken.
module c3lib_scan_deser
  import c3lib_scan_unload_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              flush_partial,
  input  logic              take,
  output logic [WORD_W-1:0] word_out,
  output logic              word_full,
  output logic              asm_full
);

  localparam int SUB_CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] asm_r;
  logic [WORD_W-1:0] asm_next_s;
  logic [SUB_CW-1:0] sub_cnt_r;
  logic              asm_full_r;
  logic              complete_s;

  // Insert the sampled tail bit at the current word position.
  always_comb begin
    asm_next_s = asm_r;
    for (int i = 0; i < WORD_W; i++) begin
      if (sample_en && (sub_cnt_r == SUB_CW'(i))) begin
        asm_next_s[i] = bit_in;
      end else begin
        asm_next_s[i] = asm_r[i];
      end
    end
  end

  // The word completes on the last slot or on the last chain bit (partial word).
  assign complete_s = sample_en &&
                      ((sub_cnt_r == SUB_CW'(WORD_W - 1)) || flush_partial);
  assign word_out   = asm_next_s;
  assign word_full  = complete_s || asm_full_r;
  assign asm_full   = asm_full_r;

  // Assembly register, fill position and parked flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_r      <= '0;
      sub_cnt_r  <= '0;
      asm_full_r <= 1'b0;
    end else if (take) begin
      asm_r      <= '0;
      sub_cnt_r  <= '0;
      asm_full_r <= 1'b0;
    end else if (sample_en) begin
      asm_r      <= asm_next_s;
      sub_cnt_r  <= sub_cnt_r + SUB_CW'(1);
      asm_full_r <= complete_s;
    end else begin
      asm_r      <= asm_r;
      sub_cnt_r  <= sub_cnt_r;
      asm_full_r <= asm_full_r;
    end
  end

endmodule

// File: rtl/c3lib_scan_chain_unload.sv
// Scan-chain tail collector: shifts the chain out under scan_en and emits
// WORD_W-bit words on a valid/ready slot, stalling the chain on backpressure.
module c3lib_scan_chain_unload
  import c3lib_scan_unload_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              chain_out,
  output logic              scan_en,
  output logic              busy,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              done
);

  localparam int NWORDS = calc_nwords(CHAIN_LEN, WORD_W);
  localparam int BIT_CW = $clog2(CHAIN_LEN + 1);
  localparam int WRD_CW = $clog2(NWORDS + 1);

  unload_state_e     state_r;
  unload_state_e     state_next_s;
  logic [BIT_CW-1:0] bit_cnt_r;
  logic [WRD_CW-1:0] word_cnt_r;
  logic [WORD_W-1:0] word_data_r;
  logic [WORD_W-1:0] asm_word_s;
  logic              word_valid_r;
  logic              word_last_r;
  logic              busy_r;
  logic              done_r;
  logic              scan_en_s;
  logic              word_full_s;
  logic              asm_full_s;
  logic              flush_partial_s;
  logic              accept_s;
  logic              slot_free_s;
  logic              take_s;
  logic              last_word_s;
  logic              start_ok_s;

  // Shift only from registered state: stop when parked or the chain is exhausted.
  assign scan_en_s       = (state_r == SHIFT) && !asm_full_s &&
                           (bit_cnt_r != BIT_CW'(CHAIN_LEN));
  assign flush_partial_s = (bit_cnt_r == BIT_CW'(CHAIN_LEN - 1));
  assign accept_s        = word_valid_r && word_ready;
  assign slot_free_s     = !word_valid_r || word_ready;
  assign take_s          = (state_r == SHIFT) && word_full_s && slot_free_s;
  assign last_word_s     = (word_cnt_r == WRD_CW'(NWORDS - 1));
  assign start_ok_s      = (state_r == IDLE) && start;

  c3lib_scan_deser #(
    .WORD_W(WORD_W)
  ) u_deser (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (scan_en_s),
    .bit_in       (chain_out),
    .flush_partial(flush_partial_s),
    .take         (take_s),
    .word_out     (asm_word_s),
    .word_full    (word_full_s),
    .asm_full     (asm_full_s)
  );

  // Unload sequencing.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = SHIFT;
        else       state_next_s = IDLE;
      end
      SHIFT: begin
        if (take_s && last_word_s) state_next_s = DRAIN;
        else                       state_next_s = SHIFT;
      end
      DRAIN: begin
        if (accept_s) state_next_s = DONE;
        else          state_next_s = DRAIN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, progress counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= '0;
      word_cnt_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == SHIFT) || (state_next_s == DRAIN);
      done_r  <= (state_next_s == DONE);
      if (start_ok_s) begin
        bit_cnt_r  <= '0;
        word_cnt_r <= '0;
      end else begin
        if (scan_en_s) bit_cnt_r <= bit_cnt_r + BIT_CW'(1);
        if (take_s)    word_cnt_r <= word_cnt_r + WRD_CW'(1);
      end
    end
  end

  // Output slot: loads only when free, so data and last stay stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data_r  <= '0;
      word_valid_r <= 1'b0;
      word_last_r  <= 1'b0;
    end else if (take_s) begin
      word_data_r  <= asm_word_s;
      word_valid_r <= 1'b1;
      word_last_r  <= last_word_s;
    end else if (accept_s) begin
      word_valid_r <= 1'b0;
      word_last_r  <= 1'b0;
    end else begin
      word_data_r  <= word_data_r;
      word_valid_r <= word_valid_r;
      word_last_r  <= word_last_r;
    end
  end

  assign scan_en    = scan_en_s;
  assign busy       = busy_r;
  assign word_data  = word_data_r;
  assign word_valid = word_valid_r;
  assign word_last  = word_last_r;
  assign done       = done_r;

endmodule

// File: tb/tb_c3lib_scan_chain_unload.sv
// Directed bench: three unload configurations driven by recirculating chain models.
module tb_c3lib_scan_chain_unload;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: CHAIN_LEN=16, WORD_W=8 ----------------
  logic        a_start, a_cout, a_sen, a_busy, a_wv, a_wr, a_wl, a_done, a_load, a_clr;
  logic [7:0]  a_wd;
  logic [15:0] a_chain, a_preset;
  logic [2:0]  a_nw;
  logic [7:0]  a_wq [0:3];
  logic        a_wlq [0:3];
  int          a_shifts, a_acc_cyc, a_done_cyc, a_done_cnt;

  c3lib_scan_chain_unload #(.CHAIN_LEN(16), .WORD_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .chain_out(a_cout), .scan_en(a_sen),
    .busy(a_busy), .word_data(a_wd), .word_valid(a_wv), .word_ready(a_wr),
    .word_last(a_wl), .done(a_done));

  assign a_cout = a_chain[0];
  always @(posedge clk) begin
    if (a_load) a_chain <= a_preset;
    else if (a_sen) a_chain <= {a_chain[0], a_chain[15:1]};
    if (a_clr) begin
      a_shifts <= 0; a_nw <= 3'd0; a_done_cnt <= 0; a_acc_cyc <= 0; a_done_cyc <= 0;
    end else begin
      if (a_sen) a_shifts <= a_shifts + 1;
      if (a_wv && a_wr) begin
        a_wq[a_nw[1:0]] <= a_wd; a_wlq[a_nw[1:0]] <= a_wl;
        a_nw <= a_nw + 3'd1; a_acc_cyc <= cyc;
      end
      if (a_done) begin a_done_cnt <= a_done_cnt + 1; a_done_cyc <= cyc; end
    end
  end

  // ---------------- instance B: CHAIN_LEN=20, WORD_W=8 ----------------
  logic        b_start, b_cout, b_sen, b_busy, b_wv, b_wr, b_wl, b_done, b_load, b_clr;
  logic [7:0]  b_wd;
  logic [19:0] b_chain;
  logic [2:0]  b_nw;
  logic [7:0]  b_wq [0:3];
  logic        b_wlq [0:3];
  int          b_shifts;

  c3lib_scan_chain_unload #(.CHAIN_LEN(20), .WORD_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .chain_out(b_cout), .scan_en(b_sen),
    .busy(b_busy), .word_data(b_wd), .word_valid(b_wv), .word_ready(b_wr),
    .word_last(b_wl), .done(b_done));

  assign b_cout = b_chain[0];
  always @(posedge clk) begin
    if (b_load) b_chain <= 20'hF_FFFF;
    else if (b_sen) b_chain <= {b_chain[0], b_chain[19:1]};
    if (b_clr) begin
      b_shifts <= 0; b_nw <= 3'd0;
    end else begin
      if (b_sen) b_shifts <= b_shifts + 1;
      if (b_wv && b_wr) begin
        b_wq[b_nw[1:0]] <= b_wd; b_wlq[b_nw[1:0]] <= b_wl; b_nw <= b_nw + 3'd1;
      end
    end
  end

  // ---------------- instance C: CHAIN_LEN=3, WORD_W=1 ----------------
  logic        c_start, c_cout, c_sen, c_busy, c_wv, c_wr, c_wl, c_done, c_load, c_clr;
  logic [0:0]  c_wd;
  logic [2:0]  c_chain;
  logic [2:0]  c_nw;
  logic        c_wq [0:3];
  logic        c_wlq [0:3];
  int          c_shifts, c_acc_cyc, c_done_cyc;

  c3lib_scan_chain_unload #(.CHAIN_LEN(3), .WORD_W(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .chain_out(c_cout), .scan_en(c_sen),
    .busy(c_busy), .word_data(c_wd), .word_valid(c_wv), .word_ready(c_wr),
    .word_last(c_wl), .done(c_done));

  assign c_cout = c_chain[0];
  always @(posedge clk) begin
    if (c_load) c_chain <= 3'b101;
    else if (c_sen) c_chain <= {c_chain[0], c_chain[2:1]};
    if (c_clr) begin
      c_shifts <= 0; c_nw <= 3'd0; c_acc_cyc <= 0; c_done_cyc <= 0;
    end else begin
      if (c_sen) c_shifts <= c_shifts + 1;
      if (c_wv && c_wr) begin
        c_wq[c_nw[1:0]] <= c_wd[0]; c_wlq[c_nw[1:0]] <= c_wl;
        c_nw <= c_nw + 3'd1; c_acc_cyc <= cyc;
      end
      if (c_done) c_done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_wr = 1'b1; b_wr = 1'b1; c_wr = 1'b1;
    a_load = 1'b1; b_load = 1'b1; c_load = 1'b1;
    a_clr = 1'b1; b_clr = 1'b1; c_clr = 1'b1;
    a_preset = 16'h3CA5;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_scan_en", 32'(a_sen), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_valid", 32'(a_wv), 32'd0);
    chk("rst_last", 32'(a_wl), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_data", 32'(a_wd), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    chk("rst_c_busy", 32'(c_busy), 32'd0);
    rst_n = 1'b1;
    a_load = 1'b0; b_load = 1'b0; c_load = 1'b0;
    a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
    @(negedge clk);

    // A: basic 16/8 unload, 0xA5 then 0x3C
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    chk("a1_busy", 32'(a_busy), 32'd1);
    for (int k = 0; k < 100 && !a_done; k++) @(negedge clk);
    chk("a1_done_seen", 32'(a_done), 32'd1);
    chk("a1_busy_in_done", 32'(a_busy), 32'd0);
    @(negedge clk);
    chk("a1_done_pulse", 32'(a_done), 32'd0);
    chk("a1_shifts", 32'(a_shifts), 32'd16);
    chk("a1_nwords", 32'(a_nw), 32'd2);
    chk("a1_word0", 32'(a_wq[0]), 32'h0000_00A5);
    chk("a1_word1", 32'(a_wq[1]), 32'h0000_003C);
    chk("a1_last0", 32'(a_wlq[0]), 32'd0);
    chk("a1_last1", 32'(a_wlq[1]), 32'd1);
    chk("a1_done_lat", 32'(a_done_cyc), 32'(a_acc_cyc + 1));
    chk("a1_done_cnt", 32'(a_done_cnt), 32'd1);

    // A: start during SHIFT and in the DONE cycle is ignored
    a_clr = 1'b1; @(negedge clk); a_clr = 1'b0;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    repeat (3) @(negedge clk);
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    for (int k = 0; k < 100 && !a_done; k++) @(negedge clk);
    chk("a2_done_seen", 32'(a_done), 32'd1);
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    chk("a2_done_start_ign", 32'(a_busy), 32'd0);
    chk("a2_shifts", 32'(a_shifts), 32'd16);
    chk("a2_nwords", 32'(a_nw), 32'd2);
    chk("a2_done_cnt", 32'(a_done_cnt), 32'd1);
    a_clr = 1'b1; a_start = 1'b1; @(negedge clk); a_clr = 1'b0; a_start = 1'b0;
    chk("a2_idle_start", 32'(a_busy), 32'd1);
    for (int k = 0; k < 100 && !a_done; k++) @(negedge clk);
    @(negedge clk);
    chk("a2_word0", 32'(a_wq[0]), 32'h0000_00A5);
    chk("a2_word1", 32'(a_wq[1]), 32'h0000_003C);
    chk("a2_shifts2", 32'(a_shifts), 32'd16);

    // A: reset after 5 bits, then unload the rotated chain
    a_clr = 1'b1; a_start = 1'b1; @(negedge clk); a_clr = 1'b0; a_start = 1'b0;
    for (int k = 0; k < 40 && a_shifts < 5; k++) @(negedge clk);
    chk("a3_shifts5", 32'(a_shifts), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("a3_rst_scan_en", 32'(a_sen), 32'd0);
    chk("a3_rst_busy", 32'(a_busy), 32'd0);
    chk("a3_rst_valid", 32'(a_wv), 32'd0);
    chk("a3_rst_data", 32'(a_wd), 32'd0);
    chk("a3_rst_last", 32'(a_wl), 32'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    a_clr = 1'b1; a_start = 1'b1; @(negedge clk); a_clr = 1'b0; a_start = 1'b0;
    for (int k = 0; k < 100 && !a_done; k++) @(negedge clk);
    @(negedge clk);
    chk("a3_word0", 32'(a_wq[0]), 32'h0000_00E5);
    chk("a3_word1", 32'(a_wq[1]), 32'h0000_0029);
    chk("a3_shifts", 32'(a_shifts), 32'd16);

    // B: 20/8 all ones -> FF, FF, 0F
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    for (int k = 0; k < 100 && !b_done; k++) @(negedge clk);
    chk("b1_done_seen", 32'(b_done), 32'd1);
    @(negedge clk);
    chk("b1_shifts", 32'(b_shifts), 32'd20);
    chk("b1_nwords", 32'(b_nw), 32'd3);
    chk("b1_word0", 32'(b_wq[0]), 32'h0000_00FF);
    chk("b1_word1", 32'(b_wq[1]), 32'h0000_00FF);
    chk("b1_word2", 32'(b_wq[2]), 32'h0000_000F);
    chk("b1_last", 32'({b_wlq[0], b_wlq[1], b_wlq[2]}), 32'd1);

    // B: backpressure for 12 cycles after the first word
    b_clr = 1'b1; b_start = 1'b1; @(negedge clk); b_clr = 1'b0; b_start = 1'b0;
    for (int k = 0; k < 40 && !b_wv; k++) @(negedge clk);
    chk("b2_first_valid", 32'(b_wv), 32'd1);
    b_wr = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2_stall_shifts", 32'(b_shifts), 32'd16);
    chk("b2_stall_scan_en", 32'(b_sen), 32'd0);
    chk("b2_stall_valid", 32'(b_wv), 32'd1);
    chk("b2_stall_data", 32'(b_wd), 32'h0000_00FF);
    chk("b2_stall_last", 32'(b_wl), 32'd0);
    chk("b2_stall_nw", 32'(b_nw), 32'd0);
    b_wr = 1'b1;
    for (int k = 0; k < 100 && !b_done; k++) @(negedge clk);
    chk("b2_done_seen", 32'(b_done), 32'd1);
    @(negedge clk);
    chk("b2_shifts", 32'(b_shifts), 32'd20);
    chk("b2_nwords", 32'(b_nw), 32'd3);
    chk("b2_word0", 32'(b_wq[0]), 32'h0000_00FF);
    chk("b2_word1", 32'(b_wq[1]), 32'h0000_00FF);
    chk("b2_word2", 32'(b_wq[2]), 32'h0000_000F);
    chk("b2_last", 32'({b_wlq[0], b_wlq[1], b_wlq[2]}), 32'd1);

    // C: WORD_W=1, chain 1,0,1
    c_start = 1'b1; @(negedge clk); c_start = 1'b0;
    for (int k = 0; k < 100 && !c_done; k++) @(negedge clk);
    chk("c1_done_seen", 32'(c_done), 32'd1);
    @(negedge clk);
    chk("c1_nwords", 32'(c_nw), 32'd3);
    chk("c1_words", 32'({c_wq[0], c_wq[1], c_wq[2]}), 32'b101);
    chk("c1_last", 32'({c_wlq[0], c_wlq[1], c_wlq[2]}), 32'b001);
    chk("c1_shifts", 32'(c_shifts), 32'd3);
    chk("c1_done_lat", 32'(c_done_cyc), 32'(c_acc_cyc + 1));
    chk("c1_idle_busy", 32'(c_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
